chf_pll_reconf: RTL and testbench
=================================

# chf_pll_reconf

Video-standard switch sequencer for the Channel F core. It sits between the OSD status word and the system PLL's reconfiguration controller. When the NTSC/PAL selection changes, it rewrites the PLL counters through the Avalon-MM management port and starts reconfiguration. It holds the core in reset (`tv_reset`) until the PLL has relocked and stayed stable.

## Interface
Parameters:
- `RESET_PAL`, 0 — standard the PLL is compiled for; value of the applied-standard register after reset (0 = NTSC, 1 = PAL).
- `LOCK_HOLD`, 1024 — consecutive cycles of synchronized `pll_locked` = 1 required before `tv_reset` is released; must be ≥ 2.

Ports:
- `clk`  in  1  management clock (CLK_50M domain); single clock of the block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pal`  in  1  requested standard (status[10]); asynchronous to `clk`.
- `pll_locked`  in  1  PLL lock indicator; asynchronous to `clk`.
- `mgmt_waitrequest`  in  1  Avalon-MM waitrequest from the reconfig controller.
- `mgmt_write`  out  1  Avalon-MM write strobe.
- `mgmt_address`  out  6  Avalon-MM register address.
- `mgmt_writedata`  out  32  Avalon-MM write data.
- `tv_reset`  out  1  core reset request; active high.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `pal` and `pll_locked` each pass through a 2-flop synchronizer, giving `pal_s` and `lock_s`.
- `cur_pal` holds the applied standard; it resets to `RESET_PAL`.
- In IDLE, when `pal_s != cur_pal`:
  - latch `tgt_pal <= pal_s`;
  - set `tv_reset <= 1`;
  - go to WR_MODE.
- Write states, in order (address, data):
  - WR_MODE: 0, 0x00000000 (waitrequest mode)
  - WR_N: 3, 0x00010000
  - WR_M: 4, 0x00000404
  - WR_C0: 5, PAL 0x00020504 / NTSC 0x00000505
  - WR_MFRAC: 7, PAL 0xA3D709E8 / NTSC 0x9745BF27
  - WR_START: 2, 0x00000000
  - Data is selected by `tgt_pal`, never by live `pal`.
- Avalon rules:
  - `mgmt_write`, `mgmt_address` and `mgmt_writedata` are registered.
  - They are held stable while `mgmt_waitrequest` = 1.
  - A write completes on the edge where `mgmt_write` = 1 and `mgmt_waitrequest` = 0.
  - The next state's write is presented on the following cycle, so there is no idle cycle between writes.
  - After WR_START completes, `mgmt_write` drops to 0.
- WAIT_LOCK:
  - A counter increments while `lock_s` = 1 and clears to 0 while `lock_s` = 0.
  - When the counter reaches `LOCK_HOLD`: `tv_reset <= 0`, `cur_pal <= tgt_pal`, go to IDLE.
- Changes of `pal` during a sequence are ignored until IDLE. The IDLE compare then restarts the sequence on the next cycle if the standard differs again (toggle-back included).
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - `mgmt_write` 0, `mgmt_address` 0, `mgmt_writedata` 0;
  - `tv_reset` 0, `busy` 0;
  - state IDLE, lock counter 0, synchronizers = 0.
- Asynchronous reset mid-write drops `mgmt_write` immediately; the transaction is abandoned, with no retry.
- If `pal` = 1 and `RESET_PAL` = 0 at reset release, a sequence starts automatically.
- `pal` toggle sampled at edge E → `tv_reset` and `busy` high after E+3 → first `mgmt_write` high after E+4.
- With `mgmt_waitrequest` tied 0, the six writes occupy exactly 6 consecutive cycles.
- Minimum `tv_reset` width = 6 + `LOCK_HOLD` + sync latency cycles.
- `pll_locked` glitch low during the hold restarts the count from 0. A sequence has no timeout.

## Structure
- Package `chf_pll_pkg` holds:
  - the state enum;
  - the address localparams `PLL_REG_MODE`/`START`/`N`/`M`/`C0`/`MFRAC`;
  - the NTSC/PAL C0 and M-frac constants;
  - the N/M constants.
- Sub-module `chf_sync2`: generic 2-flop synchronizer with async active-low reset, instantiated twice.

## Test plan
- Reset with `pal` = 0, `RESET_PAL` = 0, waitrequest 0 → outputs stay at reset values and no write occurs for 100 cycles.
- Toggle `pal` 0→1, lock held high, `LOCK_HOLD` = 4:
  - six writes (0/0, 3/0x00010000, 4/0x00000404, 5/0x00020504, 7/0xA3D709E8, 2/0) on consecutive cycles, first write 4 cycles after sampling;
  - `tv_reset` falls 4 cycles after lock counting begins.
- Waitrequest held 1 for 5 cycles on WR_C0 → address 5 and data held all 5 cycles, then WR_MFRAC follows; no write lost or duplicated.
- `pal` 1→0 during WR_M → PAL values still written; after lock, a second NTSC sequence starts with C0 = 0x00000505 and M-frac = 0x9745BF27.
- `pll_locked` drops for 1 cycle at count 3 of `LOCK_HOLD` = 4 → counter restarts; `tv_reset` released only after 4 further stable cycles.
- Assert `reset_n` = 0 during WR_N with waitrequest high → `mgmt_write` and `tv_reset` go 0 asynchronously. After release with `pal` = 1, the full sequence reruns.

Source files
------------

// File: rtl/chf_pll_pkg.sv
// Shared types and PLL reconfiguration register map for the Channel F
// video-standard switch sequencer.
package chf_pll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_MODE,
    ST_WR_N,
    ST_WR_M,
    ST_WR_C0,
    ST_WR_MFRAC,
    ST_WR_START,
    ST_WAIT_LOCK
  } pll_state_e;

  localparam logic [5:0] PLL_REG_MODE  = 6'd0;
  localparam logic [5:0] PLL_REG_START = 6'd2;
  localparam logic [5:0] PLL_REG_N     = 6'd3;
  localparam logic [5:0] PLL_REG_M     = 6'd4;
  localparam logic [5:0] PLL_REG_C0    = 6'd5;
  localparam logic [5:0] PLL_REG_MFRAC = 6'd7;

  localparam logic [31:0] PLL_MODE_WAITREQ = 32'h0000_0000;
  localparam logic [31:0] PLL_START_VAL    = 32'h0000_0000;
  localparam logic [31:0] PLL_N_VAL        = 32'h0001_0000;
  localparam logic [31:0] PLL_M_VAL        = 32'h0000_0404;
  localparam logic [31:0] PLL_C0_NTSC      = 32'h0000_0505;
  localparam logic [31:0] PLL_C0_PAL       = 32'h0002_0504;
  localparam logic [31:0] PLL_MFRAC_NTSC   = 32'h9745_BF27;
  localparam logic [31:0] PLL_MFRAC_PAL    = 32'hA3D7_09E8;

  function automatic logic [5:0] pll_wr_addr(input pll_state_e st);
    case (st)
      ST_WR_MODE:  return PLL_REG_MODE;
      ST_WR_N:     return PLL_REG_N;
      ST_WR_M:     return PLL_REG_M;
      ST_WR_C0:    return PLL_REG_C0;
      ST_WR_MFRAC: return PLL_REG_MFRAC;
      ST_WR_START: return PLL_REG_START;
      default:     return 6'd0;
    endcase
  endfunction

  function automatic logic [31:0] pll_wr_data(input pll_state_e st, input logic tgt_pal);
    case (st)
      ST_WR_MODE:  return PLL_MODE_WAITREQ;
      ST_WR_N:     return PLL_N_VAL;
      ST_WR_M:     return PLL_M_VAL;
      ST_WR_C0:    return tgt_pal ? PLL_C0_PAL : PLL_C0_NTSC;
      ST_WR_MFRAC: return tgt_pal ? PLL_MFRAC_PAL : PLL_MFRAC_NTSC;
      ST_WR_START: return PLL_START_VAL;
      default:     return 32'h0000_0000;
    endcase
  endfunction

  function automatic pll_state_e pll_wr_next(input pll_state_e st);
    case (st)
      ST_WR_MODE:  return ST_WR_N;
      ST_WR_N:     return ST_WR_M;
      ST_WR_M:     return ST_WR_C0;
      ST_WR_C0:    return ST_WR_MFRAC;
      ST_WR_MFRAC: return ST_WR_START;
      ST_WR_START: return ST_WAIT_LOCK;
      default:     return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/chf_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
module chf_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/chf_pll_reconf.sv
// NTSC/PAL switch sequencer: rewrites the PLL counters over Avalon-MM and
// holds the core in reset until the PLL has relocked and stayed stable.
module chf_pll_reconf
  import chf_pll_pkg::*;
#(
  parameter bit RESET_PAL = 1'b0,
  parameter int LOCK_HOLD = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pal,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        tv_reset,
  output logic        busy
);

  localparam int CNT_W = $clog2(LOCK_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOCK_HOLD - 1);

  logic pal_s;
  logic lock_s;

  chf_sync2 u_sync_pal (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pal),
    .q     (pal_s)
  );

  chf_sync2 u_sync_lock (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  pll_state_e       state_q, state_d;
  logic             cur_pal, cur_pal_d;
  logic             tgt_pal, tgt_pal_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             write_d;
  logic [5:0]       addr_d;
  logic [31:0]      data_d;
  logic             tv_reset_d;
  pll_state_e       wr_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cur_pal        <= RESET_PAL;
      tgt_pal        <= RESET_PAL;
      cnt            <= '0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= 6'd0;
      mgmt_writedata <= 32'h0000_0000;
      tv_reset       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_pal        <= cur_pal_d;
      tgt_pal        <= tgt_pal_d;
      cnt            <= cnt_d;
      mgmt_write     <= write_d;
      mgmt_address   <= addr_d;
      mgmt_writedata <= data_d;
      tv_reset       <= tv_reset_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_pal_d  = cur_pal;
    tgt_pal_d  = tgt_pal;
    cnt_d      = cnt;
    write_d    = mgmt_write;
    addr_d     = mgmt_address;
    data_d     = mgmt_writedata;
    tv_reset_d = tv_reset;
    wr_nxt     = pll_wr_next(state_q);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pal_s != cur_pal) begin
          tgt_pal_d  = pal_s;
          tv_reset_d = 1'b1;
          state_d    = ST_WR_MODE;
        end
      end

      ST_WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt == HOLD_LAST) begin
          cnt_d      = '0;
          tv_reset_d = 1'b0;
          cur_pal_d  = tgt_pal;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      default: begin
        // Only the first write of a sequence sees mgmt_write low; later
        // writes are presented back-to-back on completion of the previous.
        if (!mgmt_write) begin
          write_d = 1'b1;
          addr_d  = pll_wr_addr(state_q);
          data_d  = pll_wr_data(state_q, tgt_pal);
        end else if (!mgmt_waitrequest) begin
          state_d = wr_nxt;
          if (state_q == ST_WR_START) begin
            write_d = 1'b0;
          end else begin
            addr_d = pll_wr_addr(wr_nxt);
            data_d = pll_wr_data(wr_nxt, tgt_pal);
          end
        end
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_chf_pll_reconf.sv
// Scoreboard bench for chf_pll_reconf with LOCK_HOLD = 4, RESET_PAL = 0.
module tb_chf_pll_reconf;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pal;
  logic        pll_locked;
  logic        mgmt_waitrequest;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        tv_reset;
  logic        busy;

  chf_pll_reconf #(
    .RESET_PAL (1'b0),
    .LOCK_HOLD (4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pal              (pal),
    .pll_locked       (pll_locked),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_write       (mgmt_write),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .tv_reset         (tv_reset),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          wr_seen  = 0;
  int          stall_cnt = 0;
  bit          stall_prev = 1'b0;
  logic [5:0]  stall_addr;
  logic [31:0] stall_data;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
  endfunction

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [5:0] a, input logic [31:0] d);
    exp_q.push_back(wr_t'{addr: a, data: d});
  endtask

  task automatic push_seq(input logic p);
    push_wr(6'd0, 32'h0000_0000);
    push_wr(6'd3, 32'h0001_0000);
    push_wr(6'd4, 32'h0000_0404);
    push_wr(6'd5, p ? 32'h0002_0504 : 32'h0000_0505);
    push_wr(6'd7, p ? 32'hA3D7_09E8 : 32'h9745_BF27);
    push_wr(6'd2, 32'h0000_0000);
  endtask

  task automatic wait_write(input logic [5:0] a, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      wait_edges(1);
      if (mgmt_write && mgmt_address == a) found = 1'b1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic wait_done(input string name, input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      wait_edges(1);
      if (exp_q.size() == 0 && !busy && !tv_reset) done = 1'b1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // Monitor: every completed write is popped from the scoreboard; stalled
  // writes must hold address and data until accepted.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_write", 32'(mgmt_write), 32'd1);
          chk("hold_addr", 32'(mgmt_address), 32'(stall_addr));
          chk("hold_data", mgmt_writedata, stall_data);
        end
        if (mgmt_write && mgmt_waitrequest) begin
          stall_prev = 1'b1;
          stall_addr = mgmt_address;
          stall_data = mgmt_writedata;
          stall_cnt++;
        end else begin
          stall_prev = 1'b0;
        end
        if (mgmt_write && !mgmt_waitrequest) begin
          wr_seen++;
          if (exp_q.size() == 0) begin
            chk("write_expected", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(mgmt_address), 32'(e.addr));
            chk("wr_data", mgmt_writedata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int wr_before;
    reset_n          = 1'b0;
    pal              = 1'b0;
    pll_locked       = 1'b1;
    mgmt_waitrequest = 1'b0;

    // Reset values
    wait_edges(3);
    chk("rst_write", 32'(mgmt_write), 32'd0);
    chk("rst_addr", 32'(mgmt_address), 32'd0);
    chk("rst_data", mgmt_writedata, 32'd0);
    chk("rst_tv_reset", 32'(tv_reset), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    // Idle with matching standard: nothing happens
    wait_edges(100);
    chk("idle_write", 32'(mgmt_write), 32'd0);
    chk("idle_tv_reset", 32'(tv_reset), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_wr_count", 32'(wr_seen), 32'd0);

    // NTSC -> PAL with exact latency
    pal = 1'b1;
    push_seq(1'b1);
    wait_edges(2);
    chk("lat_tv_reset_e2", 32'(tv_reset), 32'd0);
    chk("lat_busy_e2", 32'(busy), 32'd0);
    wait_edges(1);
    chk("lat_tv_reset_e3", 32'(tv_reset), 32'd1);
    chk("lat_busy_e3", 32'(busy), 32'd1);
    chk("lat_write_e3", 32'(mgmt_write), 32'd0);
    wait_edges(1);
    chk("lat_write_e4", 32'(mgmt_write), 32'd1);
    chk("lat_addr_e4", 32'(mgmt_address), 32'd0);
    wait_edges(5);
    chk("last_write_e9", 32'(mgmt_write), 32'd1);
    chk("last_addr_e9", 32'(mgmt_address), 32'd2);
    wait_edges(1);
    chk("write_drop_e10", 32'(mgmt_write), 32'd0);
    wait_edges(3);
    chk("hold_tv_reset_e13", 32'(tv_reset), 32'd1);
    wait_edges(1);
    chk("release_tv_reset_e14", 32'(tv_reset), 32'd0);
    chk("release_busy_e14", 32'(busy), 32'd0);
    chk("seq1_queue_empty", 32'(exp_q.size()), 32'd0);

    // PAL -> NTSC with a 5-cycle waitrequest stall on C0
    pal = 1'b0;
    push_seq(1'b0);
    wait_write(6'd5, "find_c0");
    stall_cnt = 0;
    mgmt_waitrequest = 1'b1;
    wait_edges(5);
    mgmt_waitrequest = 1'b0;
    wait_edges(1);
    chk("stall_cycles", 32'(stall_cnt), 32'd5);
    wait_done("stall_seq_done", 200);

    // pal flips back during WR_M: PAL completes, then an NTSC sequence follows
    pal = 1'b1;
    push_seq(1'b1);
    wait_write(6'd4, "find_m");
    pal = 1'b0;
    push_seq(1'b0);
    wait_done("toggle_back_done", 400);
    wr_before = wr_seen;
    wait_edges(20);
    chk("toggle_back_settled", 32'(wr_seen - wr_before), 32'd0);
    chk("toggle_back_busy", 32'(busy), 32'd0);

    // Lock glitch at count 3 restarts the hold
    pal = 1'b1;
    push_seq(1'b1);
    wait_edges(11);
    pll_locked = 1'b0;
    wait_edges(1);
    pll_locked = 1'b1;
    wait_edges(5);
    chk("glitch_tv_reset_e17", 32'(tv_reset), 32'd1);
    wait_edges(1);
    chk("glitch_tv_reset_e18", 32'(tv_reset), 32'd0);
    chk("glitch_queue_empty", 32'(exp_q.size()), 32'd0);

    // Async reset during a stalled WR_N abandons the sequence
    pal = 1'b0;
    push_wr(6'd0, 32'h0000_0000);
    wait_write(6'd3, "find_n");
    mgmt_waitrequest = 1'b1;
    wait_edges(2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_write", 32'(mgmt_write), 32'd0);
    chk("async_tv_reset", 32'(tv_reset), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_mode_done", 32'(exp_q.size()), 32'd0);
    pal = 1'b1;
    mgmt_waitrequest = 1'b0;
    push_seq(1'b1);
    wait_edges(2);
    reset_n = 1'b1;
    wait_done("rerun_done", 200);
    chk("rerun_tv_reset", 32'(tv_reset), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
